dcim_mac_engine: RTL and testbench
==================================

// Module: dcim_mac_engine
// PURPOSE
//  Parametrised weight-stationary multiply/accumulate engine for the DCIM datapath.
//  A DEPTH x DATA_W weight store is loaded once, then an activation stream is multiplied against it
//  in address order; mode 0 emits every product, mode 1 emits one dot product per DEPTH activations.
//  Valid/ready on input and output; drops in between the host stream interface and result collection.
// PARAMETERS
//  DATA_W   8    activation/weight width (bits)
//  DEPTH    16   weight entries; power of two, >= 2
//  ADDR_W   $clog2(DEPTH)  weight address width (derived, do not override)
//  ACC_W    2*DATA_W+ADDR_W  result/accumulator width
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       IDLE only: 1-cycle pulse begins weight load
//  mode       in   1       0=elementwise product, 1=dot product; sampled on start, held to next start
//  in_valid   in   1       in_data valid
//  in_ready   out  1       engine accepts in_data this cycle
//  in_data    in   DATA_W  weight word (LOAD) or activation (RUN)
//  out_valid  out  1       out_data valid
//  out_ready  in   1       consumer accepts out_data
//  out_data   out  ACC_W   product or dot product, zero-extended/sign-extended to ACC_W
//  load_done  out  1       high while in RUN
//  busy       out  1       high in LOAD or RUN
// BEHAVIOUR
//  - One clock; reset asynchronous, active-high. Reset: state=IDLE, all outputs 0, addr=0, acc=0, pipe empty.
//  - States: IDLE -start-> LOAD; LOAD -(DEPTH-th weight accepted)-> RUN; RUN -stop(start while RUN)-> IDLE.
//    start in LOAD ignored. start in RUN: pipeline/accumulator flushed, no partial dot product emitted.
//  - Transfer = valid & ready, both sides. in_data is ignored when in_valid=0; in_ready=0 in IDLE.
//  - LOAD: in_ready=1; each transfer writes weight[addr], addr++; final transfer (addr=DEPTH-1) wraps addr to 0.
//  - RUN pipeline: S0 accept activation, synchronous weight read at addr, addr wraps DEPTH-1 -> 0;
//    S1 register act+weight; S2 product (2*DATA_W) into output register/accumulator.
//  - Latency (mode 0): out_valid 2 cycles after accepting transfer; throughput 1/cycle with out_ready=1.
//  - Mode 1: acc clears on the product of addr 0; out_valid pulses once with the sum of products
//    for addr 0..DEPTH-1; 2-cycle latency after the DEPTH-th activation. No output for intermediate terms.
//  - Backpressure: stall = out_valid & ~out_ready. Stall freezes S0..S2, addr, acc; in_ready=0 in RUN.
//    out_data and out_valid hold stable until transferred. No product lost or duplicated.
//  - in_valid gaps insert bubbles; bubbles never advance addr or acc.
//  - Width: unsigned multiply (default); ACC_W never overflows for DEPTH terms.
//  - load_done=(state==RUN); busy=(state!=IDLE). Both registered-state decodes; no combinational path in->out.
//  - Reset mid-operation: immediate return to reset values; weight storage contents undefined after reset.
// CONFIGURATION
//  DCIM_SIGNED_EN defined: weights/activations two's complement, signed multiply, out_data sign-extended.
//  DCIM_SIGNED_EN undefined: unsigned operands, out_data zero-extended. Handshake/latency identical.
// TESTING
//  1 Reset mid-RUN with out_valid=1 -> all outputs 0 next edge-independent (async), state IDLE, in_ready=0.
//  2 Load weights 1..16, mode 0, activations all 3, out_ready=1 -> outputs 3,6,...,48, then 3 again (wrap).
//  3 Mode 0, weight[0]=255, act 255 -> out_data=65025 two cycles after transfer (unsigned).
//  4 Mode 1, weights all 2, activations 1..16 -> exactly one out_valid, out_data=272; second pass repeats.
//  5 Mode 0, out_ready=0 for 5 cycles mid-stream -> in_ready=0, out_data stable, no lost/duplicated product.
//  6 DCIM_SIGNED_EN, weight=-2 (0xFE), act=3 -> out_data=-6 sign-extended; undefined macro -> 762.

Source files
------------

// File: rtl/dcim_mac_engine.sv
// rtl/dcim_mac_engine.sv - weight-stationary multiply/accumulate engine, valid/ready in and out
// Define DCIM_SIGNED_EN for two's-complement operands and a sign-extended result.
module dcim_mac_engine #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int ACC_W  = 2*DATA_W + ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              load_done,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_t              state_q;
  logic                mode_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   weight_mem [DEPTH];
  logic                s1_valid_q;
  logic                s1_first_q;
  logic                s1_last_q;
  logic [DATA_W-1:0]   s1_act_q;
  logic [DATA_W-1:0]   s1_wt_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic                out_valid_q;
  logic [ACC_W-1:0]    out_data_q;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic                stall;

`ifdef DCIM_SIGNED_EN
  assign prod     = $signed({{DATA_W{s1_act_q[DATA_W-1]}}, s1_act_q})
                  * $signed({{DATA_W{s1_wt_q[DATA_W-1]}}, s1_wt_q});
  assign prod_ext = {{ADDR_W{prod[2*DATA_W-1]}}, prod};
`else
  assign prod     = {{DATA_W{1'b0}}, s1_act_q} * {{DATA_W{1'b0}}, s1_wt_q};
  assign prod_ext = {{ADDR_W{1'b0}}, prod};
`endif

  // A held result blocks the whole pipe, so nothing upstream may be accepted.
  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = (state_q == S_LOAD) | ((state_q == S_RUN) & ~stall);
  assign acc_d     = s1_first_q ? prod_ext : acc_q + prod_ext;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign load_done = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && in_valid) begin
      weight_mem[addr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      addr_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_act_q    <= '0;
      s1_wt_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            mode_q  <= mode;
            addr_q  <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            addr_q <= addr_q + 1'b1;
            if (addr_q == ADDR_LAST) state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (start) begin
            // Stop discards anything in flight, including a partial dot product.
            state_q     <= S_IDLE;
            addr_q      <= '0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
          end else if (!stall) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
              s1_act_q   <= in_data;
              s1_wt_q    <= weight_mem[addr_q];
              s1_first_q <= (addr_q == '0);
              s1_last_q  <= (addr_q == ADDR_LAST);
              addr_q     <= addr_q + 1'b1;
            end
            if (s1_valid_q) begin
              if (mode_q) begin
                acc_q       <= acc_d;
                out_valid_q <= s1_last_q;
                if (s1_last_q) out_data_q <= acc_d;
              end else begin
                out_valid_q <= 1'b1;
                out_data_q  <= prod_ext;
              end
            end else begin
              out_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcim_mac_engine.sv
// tb/tb_dcim_mac_engine.sv - directed self-checking bench for dcim_mac_engine
// Expected values are hand-computed; DCIM_SIGNED_EN selects the signed expectations.
module tb_dcim_mac_engine;
  localparam int ACC_W = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_data;
  logic             load_done;
  logic             busy;

  int               errors = 0;
  int               checks = 0;
  logic [ACC_W-1:0] got [$];
  logic [7:0]       wbuf [16];
  logic [ACC_W-1:0] held;
  logic [ACC_W-1:0] exp_v;
  int               accepted;
  bit               stalled;

  dcim_mac_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .load_done(load_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int n = 0; n < 50 && !done; n++) begin
      if (in_ready) done = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", {31'd0, done}, 1);
  endtask

  task automatic start_pulse(input logic m);
    start = 1'b1;
    mode = m;
    step();
    start = 1'b0;
  endtask

  task automatic load_wbuf();
    for (int i = 0; i < 16; i++) send(wbuf[i]);
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {12'd0, out_data}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_load_done", {31'd0, load_done}, 0);
    rst = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 0);
    in_valid = 1'b0;
    step();

    // mode 0, weights 1..16, activations 3, with address wrap
    start_pulse(1'b0);
    chk("load_busy", {31'd0, busy}, 1);
    chk("load_in_ready", {31'd0, in_ready}, 1);
    for (int i = 0; i < 16; i++) wbuf[i] = 8'(i + 1);
    load_wbuf();
    chk("run_load_done", {31'd0, load_done}, 1);
    got.delete();
    for (int i = 0; i < 17; i++) send(8'd3);
    repeat (4) step();
    chk("m0_count", got.size(), 17);
    for (int i = 0; i < 17 && i < got.size(); i++)
      chk($sformatf("m0_prod[%0d]", i), {12'd0, got[i]}, 32'(3 * ((i % 16) + 1)));
    start_pulse(1'b0);
    chk("stop_busy", {31'd0, busy}, 0);

    // max operands, latency, start ignored during load
    start_pulse(1'b0);
    for (int i = 0; i < 16; i++) wbuf[i] = (i == 0) ? 8'd255 : 8'd0;
    for (int i = 0; i < 8; i++) send(wbuf[i]);
    start_pulse(1'b1);
    chk("load_start_ignored", {30'd0, busy, load_done}, 32'b10);
    for (int i = 8; i < 16; i++) send(wbuf[i]);
    chk("load_complete", {31'd0, load_done}, 1);
    send(8'd255);
    chk("lat_cycle1", {31'd0, out_valid}, 0);
    step();
    chk("lat_cycle2", {31'd0, out_valid}, 1);
`ifdef DCIM_SIGNED_EN
    exp_v = 20'd1;
`else
    exp_v = 20'd65025;
`endif
    chk("max_prod", {12'd0, out_data}, {12'd0, exp_v});
    step();
    start_pulse(1'b0);

    // mode 1, weights 2, activations 1..16 twice
    start_pulse(1'b1);
    for (int i = 0; i < 16; i++) wbuf[i] = 8'd2;
    load_wbuf();
    got.delete();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++) send(8'(i + 1));
    repeat (4) step();
    chk("m1_count", got.size(), 2);
    for (int i = 0; i < 2 && i < got.size(); i++)
      chk($sformatf("m1_dot[%0d]", i), {12'd0, got[i]}, 272);
    start_pulse(1'b0);

    // mode 0 backpressure for 5 cycles mid-stream
    start_pulse(1'b0);
    for (int i = 0; i < 16; i++) wbuf[i] = 8'(i + 1);
    load_wbuf();
    got.delete();
    accepted = 0;
    stalled = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd1;
    for (int n = 0; n < 100 && accepted < 16; n++) begin
      if (accepted == 6 && !stalled) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        #1;
        held = out_data;
        chk("stall_out_valid", {31'd0, out_valid}, 1);
        for (int k = 0; k < 5; k++) begin
          chk($sformatf("stall_in_ready[%0d]", k), {31'd0, in_ready}, 0);
          chk($sformatf("stall_data[%0d]", k), {12'd0, out_data}, {12'd0, held});
          step();
        end
        out_ready = 1'b1;
        #1;
      end
      if (in_ready) accepted++;
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk($sformatf("bp_prod[%0d]", i), {12'd0, got[i]}, 32'(i + 1));

    // asynchronous reset while a result is pending
    out_ready = 1'b0;
    send(8'd5);
    step();
    chk("pre_rst_out_valid", {31'd0, out_valid}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_out_data", {12'd0, out_data}, 0);
    chk("arst_in_ready", {31'd0, in_ready}, 0);
    chk("arst_busy_done", {30'd0, busy, load_done}, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    // sign handling: weight 0xFE, activation 3
    got.delete();
    start_pulse(1'b0);
    for (int i = 0; i < 16; i++) wbuf[i] = (i == 0) ? 8'hFE : 8'd0;
    load_wbuf();
    send(8'd3);
    repeat (3) step();
`ifdef DCIM_SIGNED_EN
    exp_v = 20'hFFFFA;
`else
    exp_v = 20'd762;
`endif
    chk("sign_count", got.size(), 1);
    if (got.size() > 0) chk("sign_prod", {12'd0, got[0]}, {12'd0, exp_v});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
